// File: rtl/display_scanner.sv
// Six-digit multiplexed 7-segment scanner with frame-synchronous shadow capture.
// Optional Done-driven blinking is compiled in when DONE_BLINK_EN is defined.
module display_scanner #(
  parameter int SCAN_DIV     = 16,
  parameter int BLINK_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Done,
  input  logic [6:0] seg7_points_2,
  input  logic [6:0] seg7_points_1,
  input  logic [6:0] seg7_points_0,
  input  logic [6:0] seg7_timer_1,
  input  logic [6:0] seg7_timer_0,
  input  logic [6:0] seg7_level,
  output logic [6:0] seg_out,
  output logic [5:0] an,
  output logic       frame_tick
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] LAST_SLOT = DW'(SCAN_DIV - 1);

  logic [DW-1:0] r_div_cnt;
  logic [2:0]    r_dig;
  logic [6:0]    r_sh_level;
  logic [6:0]    r_sh_timer_0;
  logic [6:0]    r_sh_timer_1;
  logic [6:0]    r_sh_points_0;
  logic [6:0]    r_sh_points_1;
  logic [6:0]    r_sh_points_2;
  logic [6:0]    r_seg;
  logic [5:0]    r_an;
  logic          r_frame_tick;

  logic          w_last_slot;
  logic          w_capture;
  logic          w_visible;
  logic [6:0]    w_seg_next;
  logic [5:0]    w_an_next;

  assign w_last_slot = (r_div_cnt == LAST_SLOT);
  assign w_capture   = w_last_slot && (r_dig == 3'd5);

  // Slot and digit counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= {DW{1'b0}};
      r_dig     <= 3'd0;
    end else if (w_last_slot) begin
      r_div_cnt <= {DW{1'b0}};
      r_dig     <= (r_dig == 3'd5) ? 3'd0 : r_dig + 3'd1;
    end else begin
      r_div_cnt <= r_div_cnt + {{(DW-1){1'b0}}, 1'b1};
    end
  end

  // Shadow registers load together only at the end of a frame, so a frame never tears
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_level    <= 7'd0;
      r_sh_timer_0  <= 7'd0;
      r_sh_timer_1  <= 7'd0;
      r_sh_points_0 <= 7'd0;
      r_sh_points_1 <= 7'd0;
      r_sh_points_2 <= 7'd0;
    end else if (w_capture) begin
      r_sh_level    <= seg7_level;
      r_sh_timer_0  <= seg7_timer_0;
      r_sh_timer_1  <= seg7_timer_1;
      r_sh_points_0 <= seg7_points_0;
      r_sh_points_1 <= seg7_points_1;
      r_sh_points_2 <= seg7_points_2;
    end
  end

`ifdef DONE_BLINK_EN
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  logic [7:0] r_blink_cnt;
  logic       r_visible;

  // Blink phase advances once per frame while the game is over
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink_cnt <= 8'd0;
      r_visible   <= 1'b1;
    end else if (w_capture) begin
      if (!Done) begin
        r_blink_cnt <= 8'd0;
        r_visible   <= 1'b1;
      end else if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= 8'd0;
        r_visible   <= ~r_visible;
      end else begin
        r_blink_cnt <= r_blink_cnt + 8'd1;
      end
    end
  end

  assign w_visible = r_visible;
`else
  logic w_unused_done;
  assign w_unused_done = Done;
  assign w_visible     = 1'b1;
`endif

  // Next digit drive; slot 0 is blanked to stop ghosting between digits
  always_comb begin
    w_an_next  = 6'b111111;
    w_seg_next = 7'd0;
    if (w_visible && (r_div_cnt != {DW{1'b0}})) begin
      case (r_dig)
        3'd0: begin w_an_next = 6'b111110; w_seg_next = r_sh_level;    end
        3'd1: begin w_an_next = 6'b111101; w_seg_next = r_sh_timer_0;  end
        3'd2: begin w_an_next = 6'b111011; w_seg_next = r_sh_timer_1;  end
        3'd3: begin w_an_next = 6'b110111; w_seg_next = r_sh_points_0; end
        3'd4: begin w_an_next = 6'b101111; w_seg_next = r_sh_points_1; end
        3'd5: begin w_an_next = 6'b011111; w_seg_next = r_sh_points_2; end
        default: begin w_an_next = 6'b111111; w_seg_next = 7'd0; end
      endcase
    end else begin
      w_an_next  = 6'b111111;
      w_seg_next = 7'd0;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an         <= 6'b111111;
      r_seg        <= 7'd0;
      r_frame_tick <= 1'b0;
    end else begin
      r_an         <= w_an_next;
      r_seg        <= w_seg_next;
      r_frame_tick <= w_capture;
    end
  end

  assign an         = r_an;
  assign seg_out    = r_seg;
  assign frame_tick = r_frame_tick;

endmodule
